axi_lite_mem_slv: RTL and testbench



---
 rtl/axi_lite_mem_slv.sv | 135 +++++++++++++
 tb/tb_axi_lite_mem_slv.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_mem_slv.sv
// axi_lite_mem_slv: AXI4-Lite responder backed by a word-addressed register array, SLVERR outside its window
package axi_lite_mem_slv_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } ax_chan_t;
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } w_chan_t;
    typedef struct packed {
        logic [1:0] resp;
    } b_chan_t;
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_chan_t;
    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;
    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } resp_t;
endpackage

module axi_lite_mem_slv #(
    parameter int unsigned          AddrWidth  = 32,
    parameter int unsigned          DataWidth  = 32,
    parameter int unsigned          NumWords   = 16,
    parameter logic [AddrWidth-1:0] BaseAddr   = '0,
    parameter type                  axi_req_t  = axi_lite_mem_slv_pkg::req_t,
    parameter type                  axi_resp_t = axi_lite_mem_slv_pkg::resp_t
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  axi_req_t  axi_req_i,
    output axi_resp_t axi_resp_o
);
    localparam int unsigned NumBytes = DataWidth / 8;
    localparam int unsigned OffBits  = $clog2(NumBytes);
    localparam int unsigned IdxWidth = $clog2(NumWords);
    localparam logic [AddrWidth-1:0] Span = AddrWidth'(NumWords * NumBytes);

    logic                 rdy_q, aw_full, w_full, b_valid, r_valid;
    logic [AddrWidth-1:0] aw_addr, aw_off, ar_off;
    logic [DataWidth-1:0] w_data, r_data;
    logic [NumBytes-1:0]  w_strb;
    logic [1:0]           b_resp, r_resp;
    logic [DataWidth-1:0] mem [NumWords];
    logic                 aw_ok, ar_ok, aw_ready, w_ready, ar_ready, commit;
    logic [IdxWidth-1:0]  aw_idx, ar_idx;
    logic                 unused_prot;

    // rdy_q keeps every ready low while reset is held and for the first edge after it
    always_comb begin
        aw_off   = aw_addr - BaseAddr;
        ar_off   = axi_req_i.ar.addr - BaseAddr;
        aw_ok    = aw_off < Span;
        ar_ok    = ar_off < Span;
        aw_idx   = aw_off[OffBits +: IdxWidth];
        ar_idx   = ar_off[OffBits +: IdxWidth];
        aw_ready = rdy_q && !aw_full && !b_valid;
        w_ready  = rdy_q && !w_full && !b_valid;
        ar_ready = rdy_q && !r_valid;
        commit   = aw_full && w_full && !b_valid;
        unused_prot = ^{axi_req_i.aw.prot, axi_req_i.ar.prot};
        axi_resp_o          = '0;
        axi_resp_o.aw_ready = aw_ready;
        axi_resp_o.w_ready  = w_ready;
        axi_resp_o.b.resp   = b_resp;
        axi_resp_o.b_valid  = b_valid;
        axi_resp_o.ar_ready = ar_ready;
        axi_resp_o.r.data   = r_data;
        axi_resp_o.r.resp   = r_resp;
        axi_resp_o.r_valid  = r_valid;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdy_q   <= 1'b0;
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            b_valid <= 1'b0;
            r_valid <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            b_resp  <= '0;
            r_data  <= '0;
            r_resp  <= '0;
            for (int i = 0; i < NumWords; i++) mem[i] <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (aw_ready && axi_req_i.aw_valid) begin
                aw_full <= 1'b1;
                aw_addr <= axi_req_i.aw.addr;
            end
            if (w_ready && axi_req_i.w_valid) begin
                w_full <= 1'b1;
                w_data <= axi_req_i.w.data;
                w_strb <= axi_req_i.w.strb;
            end
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                b_valid <= 1'b1;
                b_resp  <= aw_ok ? 2'b00 : 2'b10;
                for (int i = 0; i < NumBytes; i++)
                    if (aw_ok && w_strb[i]) mem[aw_idx][8*i +: 8] <= w_data[8*i +: 8];
            end else if (b_valid && axi_req_i.b_ready) begin
                b_valid <= 1'b0;
            end
            if (ar_ready && axi_req_i.ar_valid) begin
                r_valid <= 1'b1;
                r_data  <= ar_ok ? mem[ar_idx] : '0;
                r_resp  <= ar_ok ? 2'b00 : 2'b10;
            end else if (r_valid && axi_req_i.r_ready) begin
                r_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_mem_slv.sv
// tb_axi_lite_mem_slv: directed vector table plus hand sequences for ordering, stall, collision and reset
module tb_axi_lite_mem_slv;
    import axi_lite_mem_slv_pkg::*;

    typedef struct packed {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    req_t  req;
    resp_t rsp;
    int    n_pass = 0;
    int    n_tot = 0;

    always #5 clk = ~clk;

    axi_lite_mem_slv dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .axi_req_i (req),
        .axi_resp_o(rsp)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [1:0] resp, output int lat);
        bit aw_d = 0, w_d = 0, a_hs, w_hs;
        int n = 0;
        req.aw.addr = a;
        req.w.data = d;
        req.w.strb = s;
        req.aw_valid = 1'b1;
        req.w_valid = 1'b1;
        while (!(aw_d && w_d) && n < 20) begin
            a_hs = req.aw_valid && rsp.aw_ready;
            w_hs = req.w_valid && rsp.w_ready;
            @(negedge clk);
            n++;
            if (a_hs) begin aw_d = 1; req.aw_valid = 1'b0; end
            if (w_hs) begin w_d = 1; req.w_valid = 1'b0; end
        end
        req.aw_valid = 1'b0;
        req.w_valid = 1'b0;
        lat = 0;
        while (!rsp.b_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp.b_valid || !(aw_d && w_d)) lat = -1;
        resp = rsp.b.resp;
        req.b_ready = 1'b1;
        @(negedge clk);
        req.b_ready = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                      output bit ok);
        int n = 0;
        req.ar.addr = a;
        req.ar_valid = 1'b1;
        while (!rsp.ar_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req.ar_valid = 1'b0;
        ok = rsp.r_valid && n < 20;
        d = rsp.r.data;
        resp = rsp.r.resp;
        req.r_ready = 1'b1;
        @(negedge clk);
        req.r_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[$];
        logic [1:0]  resp;
        logic [31:0] d;
        int          lat;
        bit          ok;
        vecs.push_back('{1'b1, 32'h8,        32'hDEADBEEF, 4'hF, 32'h0,        2'b00});
        vecs.push_back('{1'b0, 32'h8,        32'h0,        4'h0, 32'hDEADBEEF, 2'b00});
        vecs.push_back('{1'b1, 32'h40,       32'h00001234, 4'hF, 32'h0,        2'b10});
        vecs.push_back('{1'b0, 32'h40,       32'h0,        4'h0, 32'h0,        2'b10});
        vecs.push_back('{1'b0, 32'h0,        32'h0,        4'h0, 32'h0,        2'b00});
        vecs.push_back('{1'b1, 32'h3C,       32'hFFFFFFFF, 4'h8, 32'h0,        2'b00});
        vecs.push_back('{1'b0, 32'h3C,       32'h0,        4'h0, 32'hFF000000, 2'b00});
        vecs.push_back('{1'b1, 32'h3E,       32'h000000AB, 4'h1, 32'h0,        2'b00});
        vecs.push_back('{1'b0, 32'h3D,       32'h0,        4'h0, 32'hFF0000AB, 2'b00});
        vecs.push_back('{1'b1, 32'hFFFFFFFC, 32'hCAFEF00D, 4'hF, 32'h0,        2'b10});
        vecs.push_back('{1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 32'h0,        2'b10});
        vecs.push_back('{1'b0, 32'h3C,       32'h0,        4'h0, 32'hFF0000AB, 2'b00});
        vecs.push_back('{1'b1, 32'h10,       32'h12345678, 4'h6, 32'h0,        2'b00});
        vecs.push_back('{1'b0, 32'h10,       32'h0,        4'h0, 32'h00345600, 2'b00});

        req = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'(rsp), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {rsp.aw_ready, rsp.w_ready, rsp.ar_ready}, 3'b111);

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                wr(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, lat);
                chk($sformatf("vec%0d_wr_lat_resp", i), {lat[7:0], resp}, {8'd1, vecs[i].exp_resp});
            end else begin
                rd(vecs[i].addr, d, resp, ok);
                chk($sformatf("vec%0d_rd", i), {ok, resp, d}, {1'b1, vecs[i].exp_resp, vecs[i].exp_data});
            end
        end

        // W three cycles ahead of AW
        req.w.data = 32'h11223344;
        req.w.strb = 4'b0101;
        req.w_valid = 1'b1;
        @(negedge clk);
        req.w_valid = 1'b0;
        chk("w_early_latched", {rsp.w_ready, rsp.b_valid}, 2'b00);
        repeat (2) @(negedge clk);
        chk("w_alone_no_commit", rsp.b_valid, 1'b0);
        req.aw.addr = 32'h4;
        req.aw_valid = 1'b1;
        @(negedge clk);
        req.aw_valid = 1'b0;
        chk("w_early_b_not_yet", rsp.b_valid, 1'b0);
        @(negedge clk);
        chk("w_early_b", {rsp.b_valid, rsp.b.resp}, 3'b100);
        req.b_ready = 1'b1;
        @(negedge clk);
        req.b_ready = 1'b0;
        rd(32'h4, d, resp, ok);
        chk("w_early_rd", {ok, resp, d}, {1'b1, 2'b00, 32'h00220044});

        // B held off by b_ready
        req.aw.addr = 32'h14;
        req.w.data = 32'h55;
        req.w.strb = 4'hF;
        req.aw_valid = 1'b1;
        req.w_valid = 1'b1;
        @(negedge clk);
        req.aw_valid = 1'b0;
        req.w_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("b_stall_%0d", k), {rsp.b_valid, rsp.b.resp, rsp.aw_ready, rsp.w_ready}, 5'b10000);
            @(negedge clk);
        end
        req.b_ready = 1'b1;
        @(negedge clk);
        req.b_ready = 1'b0;
        chk("b_release", {rsp.b_valid, rsp.aw_ready, rsp.w_ready}, 3'b011);

        // write commit and AR to the same word on one edge
        wr(32'hC, 32'h1, 4'hF, resp, lat);
        chk("coll_pre_wr", {lat[7:0], resp}, {8'd1, 2'b00});
        req.aw.addr = 32'hC;
        req.w.data = 32'hA5A5A5A5;
        req.w.strb = 4'hF;
        req.aw_valid = 1'b1;
        req.w_valid = 1'b1;
        @(negedge clk);
        req.aw_valid = 1'b0;
        req.w_valid = 1'b0;
        req.ar.addr = 32'hC;
        req.ar_valid = 1'b1;
        @(negedge clk);
        req.ar_valid = 1'b0;
        chk("coll_r_old", {rsp.r_valid, rsp.r.data}, {1'b1, 32'h1});
        chk("coll_b", {rsp.b_valid, rsp.b.resp}, 3'b100);
        req.b_ready = 1'b1;
        req.r_ready = 1'b1;
        @(negedge clk);
        req.b_ready = 1'b0;
        req.r_ready = 1'b0;
        rd(32'hC, d, resp, ok);
        chk("coll_rd_new", {ok, resp, d}, {1'b1, 2'b00, 32'hA5A5A5A5});

        // reset with both B and R pending
        wr(32'h0, 32'h77, 4'hF, resp, lat);
        chk("rst_pre_wr", {lat[7:0], resp}, {8'd1, 2'b00});
        req.aw.addr = 32'h4;
        req.w.data = 32'h99;
        req.aw_valid = 1'b1;
        req.w_valid = 1'b1;
        @(negedge clk);
        req.aw_valid = 1'b0;
        req.w_valid = 1'b0;
        req.ar.addr = 32'h0;
        req.ar_valid = 1'b1;
        @(negedge clk);
        req.ar_valid = 1'b0;
        chk("rst_pending", {rsp.b_valid, rsp.r_valid, rsp.r.data}, {2'b11, 32'h77});
        #2 rst_n = 1'b0;
        #1 chk("rst_async_clear", 64'(rsp), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(32'h0, d, resp, ok);
        chk("rst_rd0", {ok, resp, d}, {1'b1, 2'b00, 32'h0});
        rd(32'h4, d, resp, ok);
        chk("rst_rd4", {ok, resp, d}, {1'b1, 2'b00, 32'h0});
        rd(32'h8, d, resp, ok);
        chk("rst_rd8", {ok, resp, d}, {1'b1, 2'b00, 32'h0});

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
